// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the fetch sequencer: FSM state encoding and opcode nibbles.
// Pure definitions, no latency or flow control of its own.
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } fseq_state_t;

    localparam logic [3:0] HALT_OP_DEFAULT = 4'b1111;

    localparam logic [3:0] NOP = 4'b0000;
    localparam logic [3:0] LDI = 4'b0001;
    localparam logic [3:0] LD  = 4'b0010;
    localparam logic [3:0] ST  = 4'b0011;

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter, increments once per enabled cycle and sticks at all-ones.
// Single-cycle update, no backpressure; asynchronous active-low clear.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = &r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en && !w_at_max) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/issue controller: owns the PC, reads 2-byte instructions from a combinational ROM and issues them valid/ready to the CPU.
// start->first valid 2 cycles; 1 instr/2 cycles (1/cycle with FETCH_SEQ_PREFETCH_EN); holds outputs while cpu_ready=0.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = HALT_OP_DEFAULT,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data1,
    input  logic [DATA_W-1:0] rom_data2,
    output logic [DATA_W-1:0] opcode1,
    output logic [DATA_W-1:0] opcode2,
    output logic              instr_valid,
    input  logic              cpu_ready,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);

    fseq_state_t       r_state;
    fseq_state_t       w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [DATA_W-1:0] w_op1_nxt;
    logic [DATA_W-1:0] w_op2_nxt;
    logic              r_vld;
    logic              w_vld_nxt;
    logic              w_accept;
    logic              w_halt_op;
    logic [ADDR_W-1:0] w_rom_addr;

    // r_vld is only ever set in ISSUE, so it alone qualifies the handshake.
    assign w_accept  = r_vld & cpu_ready;
    assign w_halt_op = (r_op1[DATA_W-1 -: 4] == HALT_OP);
    assign w_pc_inc  = r_pc + ADDR_W'(2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_op1_nxt   = r_op1;
        w_op2_nxt   = r_op2;
        w_vld_nxt   = r_vld;
        w_rom_addr  = r_pc;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                w_op1_nxt   = rom_data1;
                w_op2_nxt   = rom_data2;
                w_vld_nxt   = 1'b1;
                w_state_nxt = ISSUE;
            end
            ISSUE: begin
`ifdef FETCH_SEQ_PREFETCH_EN
                // Look ahead at whatever the PC will become on this accept.
                w_rom_addr = branch_taken ? branch_target : w_pc_inc;
`endif
                if (w_accept) begin
                    if (w_halt_op) begin
                        w_state_nxt = HALT;
                        w_vld_nxt   = 1'b0;
                    end else begin
                        w_pc_nxt = branch_taken ? branch_target : w_pc_inc;
`ifdef FETCH_SEQ_PREFETCH_EN
                        w_op1_nxt = rom_data1;
                        w_op2_nxt = rom_data2;
                        w_vld_nxt = 1'b1;
`else
                        w_state_nxt = FETCH;
                        w_vld_nxt   = 1'b0;
`endif
                    end
                end
            end
            HALT: begin
                w_vld_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_vld_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc  <= RESET_PC;
            r_op1 <= '0;
            r_op2 <= '0;
            r_vld <= 1'b0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_op1 <= w_op1_nxt;
            r_op2 <= w_op2_nxt;
            r_vld <= w_vld_nxt;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_instr_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .i_en    (w_accept),
        .o_count (instr_count)
    );

    assign rom_address = w_rom_addr;
    assign opcode1     = r_op1;
    assign opcode2     = r_op2;
    assign instr_valid = r_vld;
    assign pc          = r_pc;
    assign halted      = (r_state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed programs in a behavioural ROM, expected
// issued pairs queued by the stimulus and checked by an independent monitor on each accept.
module tb_fetch_sequencer;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              cpu_ready = 1'b0;
    logic              branch_taken = 1'b0;
    logic [ADDR_W-1:0] branch_target = '0;
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_data1;
    logic [DATA_W-1:0] rom_data2;
    logic [DATA_W-1:0] opcode1;
    logic [DATA_W-1:0] opcode2;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic [CNT_W-1:0]  instr_count;

    logic [7:0] rom [256];

    assign rom_data1 = rom[rom_address];
    assign rom_data2 = (rom_address == 8'hFF) ? 8'h00 : rom[rom_address + 8'd1];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .rom_address   (rom_address),
        .rom_data1     (rom_data1),
        .rom_data2     (rom_data2),
        .opcode1       (opcode1),
        .opcode2       (opcode2),
        .instr_valid   (instr_valid),
        .cpu_ready     (cpu_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .halted        (halted),
        .instr_count   (instr_count)
    );

    typedef struct packed {
        logic [7:0] op1;
        logic [7:0] op2;
        logic [7:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: at the negedge before an accepting edge, compare the held pair against the queue head.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && instr_valid && cpu_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_issue: got pc 0x%0h, expected no issue", pc);
            end else begin
                e = sb.pop_front();
                check($sformatf("issue_op1@%0h", e.pc), {24'h0, opcode1}, {24'h0, e.op1});
                check($sformatf("issue_op2@%0h", e.pc), {24'h0, opcode2}, {24'h0, e.op2});
                check($sformatf("issue_pc@%0h", e.pc),  {24'h0, pc},      {24'h0, e.pc});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vld(input string name);
        int i;
        i = 0;
        while (!instr_valid && i < 20) begin
            tick();
            i++;
        end
        check(name, {31'h0, instr_valid}, 32'h1);
    endtask

    task automatic issue(input logic [7:0] o1, input logic [7:0] o2, input logic [7:0] p,
                         input logic br, input logic [7:0] tgt);
        sb.push_back(exp_t'{op1: o1, op2: o2, pc: p});
        wait_vld($sformatf("wait_valid@%0h", p));
        cpu_ready     = 1'b1;
        branch_taken  = br;
        branch_target = tgt;
        tick();
        cpu_ready     = 1'b0;
        branch_taken  = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        int i;
        i = 0;
        while (!halted && i < 20) begin
            tick();
            i++;
        end
        check(name, {31'h0, halted}, 32'h1);
    endtask

    task automatic apply_reset(input string name);
        check({name, "_sb_empty"}, sb.size(), 32'h0);
        cpu_ready    = 1'b0;
        branch_taken = 1'b0;
        reset        = 1'b0;
        #2;
        check({name, "_pc"},     {24'h0, pc},          32'h0);
        check({name, "_count"},  {16'h0, instr_count}, 32'h0);
        check({name, "_valid"},  {31'h0, instr_valid}, 32'h0);
        check({name, "_halted"}, {31'h0, halted},      32'h0);
        check({name, "_op1"},    {24'h0, opcode1},     32'h0);
        check({name, "_op2"},    {24'h0, opcode2},     32'h0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int nk;
        logic exp_v;
        for (int a = 0; a < 256; a++) rom[a] = 8'h00;
        rom[0] = 8'h10; rom[1] = 8'hFF; rom[2] = 8'h30; rom[3] = 8'h83;
        rom[4] = 8'h20; rom[5] = 8'h83; rom[6] = 8'hF0; rom[7] = 8'h00;
        rom[8'h40] = 8'h55; rom[8'h41] = 8'h66; rom[8'h42] = 8'h20; rom[8'h43] = 8'h07;
        rom[8'hFE] = 8'h31; rom[8'hFF] = 8'h44;

        #1;
        apply_reset("reset0");
        check("reset0_romaddr", {24'h0, rom_address}, 32'h0);

        // Straight-line program, ready held high.
        sb.push_back(exp_t'{op1: 8'h10, op2: 8'hFF, pc: 8'h00});
        sb.push_back(exp_t'{op1: 8'h30, op2: 8'h83, pc: 8'h02});
        sb.push_back(exp_t'{op1: 8'h20, op2: 8'h83, pc: 8'h04});
        sb.push_back(exp_t'{op1: 8'hF0, op2: 8'h00, pc: 8'h06});
        cpu_ready = 1'b1;
        start     = 1'b1;
`ifdef FETCH_SEQ_PREFETCH_EN
        nk = 5;
`else
        nk = 6;
`endif
        for (int k = 1; k <= nk; k++) begin
            tick();
`ifdef FETCH_SEQ_PREFETCH_EN
            exp_v = (k >= 2);
`else
            exp_v = (k >= 2) && (k % 2 == 0);
`endif
            check($sformatf("t1_valid_cyc%0d", k), {31'h0, instr_valid}, {31'h0, exp_v});
        end
`ifndef FETCH_SEQ_PREFETCH_EN
        tick();
`endif
        check("t1_count3", {16'h0, instr_count}, 32'd3);
        wait_halt("t1_halted");
        check("t1_halt_valid", {31'h0, instr_valid}, 32'h0);
        check("t1_halt_pc",    {24'h0, pc},          32'h6);
        check("t1_count4",     {16'h0, instr_count}, 32'd4);
        cpu_ready = 1'b0;
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t1_start_ignored_halted", {31'h0, halted},      32'h1);
        check("t1_start_ignored_valid",  {31'h0, instr_valid}, 32'h0);
        check("t1_start_ignored_pc",     {24'h0, pc},          32'h6);
        start = 1'b1;
        apply_reset("reset1");

        // Backpressure: hold the second instruction for 5 cycles.
        issue(8'h10, 8'hFF, 8'h00, 1'b0, 8'h00);
        sb.push_back(exp_t'{op1: 8'h30, op2: 8'h83, pc: 8'h02});
        wait_vld("t2_wait");
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t2_hold_op1_%0d", k), {24'h0, opcode1},     32'h30);
            check($sformatf("t2_hold_op2_%0d", k), {24'h0, opcode2},     32'h83);
            check($sformatf("t2_hold_pc_%0d", k),  {24'h0, pc},          32'h02);
            check($sformatf("t2_hold_cnt_%0d", k), {16'h0, instr_count}, 32'd1);
            tick();
        end
        cpu_ready = 1'b1;
        tick();
        cpu_ready = 1'b0;
        check("t2_count_after", {16'h0, instr_count}, 32'd2);
        apply_reset("reset2");

        // Taken branch, then a stray branch outside an accept.
        issue(8'h10, 8'hFF, 8'h00, 1'b0, 8'h00);
        issue(8'h30, 8'h83, 8'h02, 1'b1, 8'h40);
        wait_vld("t3_wait_target");
        branch_taken  = 1'b1;
        branch_target = 8'h80;
        tick();
        branch_taken  = 1'b0;
        check("t3_stray_branch_pc",  {24'h0, pc},      32'h40);
        check("t3_stray_branch_op1", {24'h0, opcode1}, 32'h55);
        issue(8'h55, 8'h66, 8'h40, 1'b0, 8'h00);
        issue(8'h20, 8'h07, 8'h42, 1'b0, 8'h00);
        check("t3_count", {16'h0, instr_count}, 32'd4);
        apply_reset("reset3");

        // PC wrap at 254, ROM boundary at 255, halt ignores branch.
        issue(8'h10, 8'hFF, 8'h00, 1'b1, 8'hFE);
        issue(8'h31, 8'h44, 8'hFE, 1'b0, 8'h00);
        issue(8'h10, 8'hFF, 8'h00, 1'b1, 8'hFF);
        issue(8'h44, 8'h00, 8'hFF, 1'b1, 8'h06);
        issue(8'hF0, 8'h00, 8'h06, 1'b1, 8'h40);
        wait_halt("t4_halted");
        check("t4_halt_pc",   {24'h0, pc},          32'h6);
        check("t4_count",     {16'h0, instr_count}, 32'd5);
        check("t4_sb_empty",  sb.size(),            32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
